// File: rtl/seg7_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg7_msg_arbiter
// Purpose  : Decides what the 8-digit 7-segment display shows. A live "note"
//            readout is shown by default; "alert" messages pre-empt it for a
//            fixed hold time (TICK_DIV*HOLD_TICKS cycles). One further alert
//            may queue behind the one on display. When the alerts are done,
//            the display returns to the newest note.
// Ports    : clk           - system clock, rising edge
//            reset         - asynchronous active-high reset
//            clear         - synchronous: blank display, drop note + pending
//            note_valid    - note_text valid (always accepted)
//            note_text     - 8 ASCII chars, byte k -> digit k
//            alert_valid   - alert request
//            alert_ready   - alert accepted on alert_valid & alert_ready
//            alert_text    - 8 ASCII chars for the alert
//            asciix8       - registered display bus to the 7-seg driver
//            showing_alert - high while in ALERT
//            state         - 00 BLANK, 01 NOTE, 10 ALERT
// Revision : 1.0 - initial release
// ============================================================================
module seg7_msg_arbiter #(
  parameter int          TICK_DIV   = 100000,
  parameter int          HOLD_TICKS = 2000,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        note_valid,
  input  logic [63:0] note_text,
  input  logic        alert_valid,
  output logic        alert_ready,
  input  logic [63:0] alert_text,
  output logic [63:0] asciix8,
  output logic        showing_alert,
  output logic [1:0]  state
);

  localparam logic [1:0]  ST_BLANK = 2'b00;
  localparam logic [1:0]  ST_NOTE  = 2'b01;
  localparam logic [1:0]  ST_ALERT = 2'b10;

  localparam logic [63:0] BLANKS = {8{BLANK_CHAR}};

  // Counter widths stay at least 1 bit so TICK_DIV=1 / HOLD_TICKS=1 still work.
  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS - 1);

  // Registered state
  logic [63:0]   note_buf;
  logic          note_seen;      // a note has arrived since reset/clear
  logic [63:0]   pending_buf;
  logic          pending_valid;
  logic [PW-1:0] prescaler;
  logic [HW-1:0] hold_cnt;

  // Next-state values
  logic [1:0]    state_nxt;
  logic [63:0]   disp_nxt;
  logic [63:0]   note_buf_nxt;
  logic          note_seen_nxt;
  logic [63:0]   pending_buf_nxt;
  logic          pending_valid_nxt;
  logic [PW-1:0] prescaler_nxt;
  logic [HW-1:0] hold_cnt_nxt;

  logic tick;
  logic expiry;
  logic handshake;

  assign tick      = (state == ST_ALERT) && (prescaler == PRE_MAX);
  assign expiry    = tick && (hold_cnt == HOLD_MAX);
  assign handshake = alert_valid && alert_ready;

  // --------------------------------------------------------------------------
  // State / datapath register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_BLANK;
      showing_alert <= 1'b0;
      asciix8       <= BLANKS;
      note_buf      <= BLANKS;
      note_seen     <= 1'b0;
      pending_buf   <= BLANKS;
      pending_valid <= 1'b0;
      prescaler     <= '0;
      hold_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      showing_alert <= (state_nxt == ST_ALERT);
      asciix8       <= disp_nxt;
      note_buf      <= note_buf_nxt;
      note_seen     <= note_seen_nxt;
      pending_buf   <= pending_buf_nxt;
      pending_valid <= pending_valid_nxt;
      prescaler     <= prescaler_nxt;
      hold_cnt      <= hold_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt         = state;
    disp_nxt          = asciix8;
    note_buf_nxt      = note_buf;
    note_seen_nxt     = note_seen;
    pending_buf_nxt   = pending_buf;
    pending_valid_nxt = pending_valid;
    prescaler_nxt     = prescaler;
    hold_cnt_nxt      = hold_cnt;

    // The note is captured in every state; in ALERT only its display waits.
    if (note_valid) begin
      note_buf_nxt  = note_text;
      note_seen_nxt = 1'b1;
    end

    // Timer advances only while an alert is on display.
    if (state == ST_ALERT) begin
      if (tick) begin
        prescaler_nxt = '0;
        hold_cnt_nxt  = hold_cnt + HW'(1);
      end else begin
        prescaler_nxt = prescaler + PW'(1);
      end
    end

    if (clear) begin
      state_nxt         = ST_BLANK;
      disp_nxt          = BLANKS;
      note_buf_nxt      = BLANKS;
      note_seen_nxt     = 1'b0;
      pending_valid_nxt = 1'b0;
      prescaler_nxt     = '0;
      hold_cnt_nxt      = '0;
    end else begin
      case (state)
        ST_BLANK, ST_NOTE: begin
          if (handshake) begin
            state_nxt     = ST_ALERT;
            disp_nxt      = alert_text;
            prescaler_nxt = '0;
            hold_cnt_nxt  = '0;
          end else if (note_valid) begin
            state_nxt = ST_NOTE;
            disp_nxt  = note_text;
          end
        end
        ST_ALERT: begin
          if (expiry) begin
            // Every exit path from an expiry restarts the timer from zero.
            prescaler_nxt = '0;
            hold_cnt_nxt  = '0;
            if (pending_valid) begin
              disp_nxt          = pending_buf;
              pending_valid_nxt = 1'b0;
            end else if (handshake) begin
              disp_nxt = alert_text;
            end else if (note_seen_nxt) begin
              // note_buf_nxt already includes a note arriving this cycle.
              state_nxt = ST_NOTE;
              disp_nxt  = note_buf_nxt;
            end else begin
              state_nxt = ST_BLANK;
              disp_nxt  = BLANKS;
            end
          end else if (handshake) begin
            pending_buf_nxt   = alert_text;
            pending_valid_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_BLANK;
          disp_nxt  = BLANKS;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    alert_ready = ~pending_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_msg_arbiter
// Purpose  : Self-checking bench for seg7_msg_arbiter (TICK_DIV=4,
//            HOLD_TICKS=3). A queue-based model of the display schedule is
//            compared against the DUT on every falling edge; directed
//            literal checks pin key points of each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_msg_arbiter;

  localparam int TD       = 4;
  localparam int HT       = 3;
  localparam int HOLD_CYC = TD * HT;

  localparam logic [63:0] BLANKS  = 64'h2020202020202020;
  localparam logic [63:0] NOTE_A4 = 64'h4134202034343020; // "A4  440 "
  localparam logic [63:0] NOTE_C5 = 64'h4335202035323320; // "C5  523 "
  localparam logic [63:0] NOTE_D3 = 64'h4433202031343720; // "D3  147 "
  localparam logic [63:0] ERR_LO  = 64'h45727220204c6f20; // "Err  Lo "
  localparam logic [63:0] ERR_HI  = 64'h4572722020486920; // "Err  Hi "
  localparam logic [63:0] ERR_X   = 64'h4572722020582020; // "Err  X  "

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        note_valid = 1'b0;
  logic [63:0] note_text = '0;
  logic        alert_valid = 1'b0;
  logic [63:0] alert_text = '0;
  logic        alert_ready;
  logic [63:0] asciix8;
  logic        showing_alert;
  logic [1:0]  state;

  seg7_msg_arbiter #(
    .TICK_DIV   (TD),
    .HOLD_TICKS (HT),
    .BLANK_CHAR (8'h20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .note_valid    (note_valid),
    .note_text     (note_text),
    .alert_valid   (alert_valid),
    .alert_ready   (alert_ready),
    .alert_text    (alert_text),
    .asciix8       (asciix8),
    .showing_alert (showing_alert),
    .state         (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: m_aq holds the alert on display (front) plus at most one waiting.
  // m_remain counts display cycles left for the front alert.
  // --------------------------------------------------------------------------
  logic [1:0]  m_state;
  logic [63:0] m_disp;
  logic [63:0] m_note;
  bit          m_seen;
  logic [63:0] m_aq[$];
  int          m_remain;
  bit          check_en = 1'b0;

  task automatic model_reset();
    m_state  = 2'd0;
    m_disp   = BLANKS;
    m_note   = BLANKS;
    m_seen   = 1'b0;
    m_aq.delete();
    m_remain = 0;
  endtask

  task automatic model_step();
    bit hs;
    if (reset || clear) begin
      model_reset();
      return;
    end
    hs = alert_valid && (m_aq.size() < 2);
    if (note_valid) begin
      m_note = note_text;
      m_seen = 1'b1;
    end
    if (m_state != 2'd2) begin
      if (hs) begin
        m_aq.push_back(alert_text);
        m_remain = HOLD_CYC;
        m_state  = 2'd2;
        m_disp   = alert_text;
      end else if (note_valid) begin
        m_state = 2'd1;
        m_disp  = note_text;
      end
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        void'(m_aq.pop_front());
        if (hs) m_aq.push_back(alert_text);
        if (m_aq.size() > 0) begin
          m_disp   = m_aq[0];
          m_remain = HOLD_CYC;
        end else if (m_seen) begin
          m_state = 2'd1;
          m_disp  = m_note;
        end else begin
          m_state = 2'd0;
          m_disp  = BLANKS;
        end
      end else if (hs) begin
        m_aq.push_back(alert_text);
      end
    end
  endtask

  // Compare process: every falling edge, DUT vs model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("asciix8", asciix8, m_disp);
      chk("state", 64'(state), 64'(m_state));
      chk("showing_alert", 64'(showing_alert), 64'(m_state == 2'd2));
      chk("alert_ready", 64'(alert_ready), 64'(m_aq.size() < 2));
    end
  end

  // One clock of stimulus; inputs change only just after a falling edge.
  task automatic cyc(input bit nv, input logic [63:0] nt, input bit av,
                     input logic [63:0] at, input bit clr);
    note_valid  = nv;
    note_text   = nt;
    alert_valid = av;
    alert_text  = at;
    clear       = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  int sa_cnt;

  initial begin
    model_reset();
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_asciix8", asciix8, BLANKS);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ready", 64'(alert_ready), 64'd1);

    // Scenario 1: first note
    cyc(1'b1, NOTE_A4, 1'b0, '0, 1'b0);
    chk("s1_state", 64'(state), 64'd1);
    chk("s1_asciix8", asciix8, 64'h4134202034343020);
    chk("s1_ready", 64'(alert_ready), 64'd1);

    // Scenario 2: single alert held exactly HOLD_CYC cycles
    cyc(1'b0, '0, 1'b1, ERR_LO, 1'b0);
    chk("s2_alert_shown", asciix8, ERR_LO);
    sa_cnt = int'(showing_alert);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      sa_cnt += int'(showing_alert);
    end
    chk("s2_hold_cycles", 64'(sa_cnt), 64'd12);
    chk("s2_revert_note", asciix8, NOTE_A4);

    // Scenario 3: queued second alert, refused third, then newest note
    cyc(1'b0, '0, 1'b1, ERR_LO, 1'b0);
    idle(1);
    cyc(1'b1, NOTE_C5, 1'b0, '0, 1'b0);
    chk("s3_note_deferred", asciix8, ERR_LO);
    cyc(1'b0, '0, 1'b1, ERR_HI, 1'b0);
    chk("s3_ready_low", 64'(alert_ready), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, ERR_X, 1'b0);
    idle(30);
    chk("s3_final_note", asciix8, NOTE_C5);

    // Scenario 4: alert and note in the same cycle
    cyc(1'b1, NOTE_D3, 1'b1, ERR_LO, 1'b0);
    chk("s4_alert_wins", asciix8, ERR_LO);
    idle(14);
    chk("s4_note_after", asciix8, NOTE_D3);

    // Scenario 5: clear during ALERT with pending full; inputs in the
    // clear cycle are discarded
    cyc(1'b0, '0, 1'b1, ERR_LO, 1'b0);
    cyc(1'b0, '0, 1'b1, ERR_HI, 1'b0);
    idle(1);
    cyc(1'b1, NOTE_A4, 1'b1, ERR_X, 1'b1);
    chk("s5_state", 64'(state), 64'd0);
    chk("s5_asciix8", asciix8, 64'h2020202020202020);
    chk("s5_ready", 64'(alert_ready), 64'd1);
    idle(20);
    chk("s5_still_blank", asciix8, BLANKS);

    // Alert from BLANK with no note since clear -> back to BLANK; a second
    // alert offered on the expiry edge loads directly
    cyc(1'b0, '0, 1'b1, ERR_LO, 1'b0);
    idle(HOLD_CYC - 1);
    cyc(1'b0, '0, 1'b1, ERR_HI, 1'b0);
    chk("s5b_direct_load", asciix8, ERR_HI);
    chk("s5b_showing", 64'(showing_alert), 64'd1);
    idle(14);
    chk("s5b_back_blank", 64'(state), 64'd0);

    // Scenario 6: asynchronous reset mid-alert
    cyc(1'b1, NOTE_A4, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, ERR_LO, 1'b0);
    cyc(1'b0, '0, 1'b1, ERR_HI, 1'b0);
    idle(3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("s6_async_asciix8", asciix8, BLANKS);
    chk("s6_async_state", 64'(state), 64'd0);
    chk("s6_async_showing", 64'(showing_alert), 64'd0);
    chk("s6_async_ready", 64'(alert_ready), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    cyc(1'b1, NOTE_A4, 1'b0, '0, 1'b0);
    chk("s6_note_state", 64'(state), 64'd1);
    chk("s6_note_asciix8", asciix8, 64'h4134202034343020);
    idle(15);
    chk("s6_pending_lost", asciix8, NOTE_A4);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
